// File: rtl/dcache_pkg.sv
// Shared constants and types for the data-cache memory-side bus interface.
package dcache_pkg;

    localparam int WIDTH    = 64;
    localparam int BLOCKSZ  = 512;
    localparam int BEATS    = BLOCKSZ / WIDTH;
    localparam int OFFWIDTH = 6;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD_BEATS,
        WR_ACK,
        DONE
    } memif_state_t;

    typedef logic [BLOCKSZ-1:0] line_t;

endpackage

// File: rtl/line_assembler.sv
// Collects response beats into a cache line, starting at word w0 and wrapping.
module line_assembler
    import dcache_pkg::*;
#(
    parameter int BEAT_W = WIDTH,
    parameter int NBEATS = BEATS,
    parameter int CNT_W  = $clog2(NBEATS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         w0,
    input  logic                     beat_valid,
    input  logic [BEAT_W-1:0]        beat_data,
    output logic [BEAT_W*NBEATS-1:0] line,
    output logic                     last_beat
);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         w0_q, w0_d;
    logic [CNT_W-1:0]         idx;
    logic [BEAT_W*NBEATS-1:0] line_q, line_d;

    // Word slot wraps modulo the line length.
    assign idx = w0_q + cnt_q;

    always_comb begin
        cnt_d  = cnt_q;
        w0_d   = w0_q;
        line_d = line_q;
        if (start) begin
            cnt_d = '0;
            w0_d  = w0;
        end else if (beat_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
            line_d[idx*BEAT_W +: BEAT_W] = beat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            w0_q   <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            w0_q   <= w0_d;
            line_q <= line_d;
        end
    end

    assign line      = line_q;
    assign last_beat = beat_valid && !start && (cnt_q == CNT_W'(NBEATS - 1));

endmodule

// File: rtl/dcache_mem_if.sv
// Data-cache memory-side bus interface: line fills and write-through words.
// Optional critical-word-first fills under macro DCACHE_MEMIF_CWF_EN.
//
// state    | meaning
// IDLE     | waiting for cache_req; request captured on leaving
// REQ      | bus request presented until handshake
// RD_BEATS | accepting fill beats into the line assembler
// WR_ACK   | waiting for the single write acknowledge beat
// DONE     | one-cycle completion pulse to the cache
module dcache_mem_if
    import dcache_pkg::*;
#(
    parameter int BLOCKSZ     = dcache_pkg::BLOCKSZ,
    parameter int WIDTH       = dcache_pkg::WIDTH,
    parameter int ADDRESSSIZE = 64,
    parameter int BEATS       = BLOCKSZ / WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cache_req,
    input  logic                   cache_wr_en,
    input  logic [ADDRESSSIZE-1:0] cache_addr,
    input  logic [WIDTH-1:0]       cache_wdata,
    output logic [BLOCKSZ-1:0]     cache_block,
    output logic                   cache_valid,
    output logic                   bus_req_valid,
    input  logic                   bus_req_ready,
    output logic [ADDRESSSIZE-1:0] bus_req_addr,
    output logic                   bus_req_wr,
    output logic [WIDTH-1:0]       bus_req_data,
    input  logic                   bus_resp_valid,
    input  logic [WIDTH-1:0]       bus_resp_data,
    output logic                   bus_resp_ready
);

    localparam int CNT_W    = $clog2(BEATS);
    localparam int WORD_OFF = $clog2(WIDTH / 8);
    localparam int LINE_OFF = $clog2(BLOCKSZ / 8);

    memif_state_t state_q, state_d;

    logic [ADDRESSSIZE-1:0] req_addr_q, req_addr_d;
    logic                   req_wr_q, req_wr_d;
    logic [WIDTH-1:0]       req_data_q, req_data_d;
    logic                   req_valid_q, req_valid_d;
    logic                   cache_valid_q, cache_valid_d;

    logic                   capture;
    logic                   fill_beat;
    logic                   last_beat;
    logic [ADDRESSSIZE-1:0] fill_addr;
    logic [CNT_W-1:0]       start_w0;

`ifdef DCACHE_MEMIF_CWF_EN
    assign fill_addr = cache_addr & ~ADDRESSSIZE'((WIDTH / 8) - 1);
    assign start_w0  = cache_addr[LINE_OFF-1:WORD_OFF];
`else
    assign fill_addr = cache_addr & ~ADDRESSSIZE'((BLOCKSZ / 8) - 1);
    assign start_w0  = '0;
`endif

    assign capture        = (state_q == IDLE) && cache_req;
    assign bus_resp_ready = (state_q == RD_BEATS) || (state_q == WR_ACK);
    assign fill_beat      = bus_resp_valid && (state_q == RD_BEATS);

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        req_wr_d   = req_wr_q;
        req_data_d = req_data_q;
        case (state_q)
            IDLE: begin
                if (cache_req) begin
                    state_d    = REQ;
                    req_addr_d = cache_wr_en ? cache_addr : fill_addr;
                    req_wr_d   = cache_wr_en;
                    req_data_d = cache_wdata;
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    state_d = req_wr_q ? WR_ACK : RD_BEATS;
                end
            end
            RD_BEATS: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            WR_ACK: begin
                if (bus_resp_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered outputs follow the state being entered.
        req_valid_d   = (state_d == REQ);
        cache_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            req_wr_q      <= 1'b0;
            req_data_q    <= '0;
            req_valid_q   <= 1'b0;
            cache_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            req_wr_q      <= req_wr_d;
            req_data_q    <= req_data_d;
            req_valid_q   <= req_valid_d;
            cache_valid_q <= cache_valid_d;
        end
    end

    line_assembler #(
        .BEAT_W (WIDTH),
        .NBEATS (BEATS),
        .CNT_W  (CNT_W)
    ) u_line_assembler (
        .clk        (clk),
        .rst        (rst),
        .start      (capture),
        .w0         (start_w0),
        .beat_valid (fill_beat),
        .beat_data  (bus_resp_data),
        .line       (cache_block),
        .last_beat  (last_beat)
    );

    assign cache_valid   = cache_valid_q;
    assign bus_req_valid = req_valid_q;
    assign bus_req_addr  = req_addr_q;
    assign bus_req_wr    = req_wr_q;
    assign bus_req_data  = req_data_q;

endmodule

// File: tb/tb_dcache_mem_if.sv
// Directed bench for dcache_mem_if: fills, writes, stalls, reset and back-to-back.
module tb_dcache_mem_if;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cache_req = 1'b0;
    logic         cache_wr_en = 1'b0;
    logic [63:0]  cache_addr = '0;
    logic [63:0]  cache_wdata = '0;
    logic [511:0] cache_block;
    logic         cache_valid;
    logic         bus_req_valid;
    logic         bus_req_ready = 1'b0;
    logic [63:0]  bus_req_addr;
    logic         bus_req_wr;
    logic [63:0]  bus_req_data;
    logic         bus_resp_valid = 1'b0;
    logic [63:0]  bus_resp_data = '0;
    logic         bus_resp_ready;

    always #5 clk = ~clk;

    dcache_mem_if dut (
        .clk            (clk),
        .rst            (rst),
        .cache_req      (cache_req),
        .cache_wr_en    (cache_wr_en),
        .cache_addr     (cache_addr),
        .cache_wdata    (cache_wdata),
        .cache_block    (cache_block),
        .cache_valid    (cache_valid),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wr     (bus_req_wr),
        .bus_req_data   (bus_req_data),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_data  (bus_resp_data),
        .bus_resp_ready (bus_resp_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus responder knobs and observations.
    int          req_stall = 0;
    int          stall_cnt = 0;
    int          gap_at = -1;
    int          gap_len = 0;
    int          gap_done = 0;
    int          beat_i = 0;
    logic [63:0] beat_base = '0;
    logic [63:0] base_cur = '0;
    logic [63:0] hs_addr = '0;
    logic [63:0] hs_data = '0;
    logic        hs_wr = 1'b0;
    bit          seen_req = 0;
    bit          unstable = 0;
    logic [63:0] r_addr0 = '0;
    logic [63:0] r_data0 = '0;
    logic        r_wr0 = 1'b0;

    always @(negedge clk) begin
        if (bus_req_valid) begin
            if (!seen_req) begin
                seen_req = 1;
                r_addr0  = bus_req_addr;
                r_data0  = bus_req_data;
                r_wr0    = bus_req_wr;
            end else if (bus_req_addr !== r_addr0 || bus_req_data !== r_data0 || bus_req_wr !== r_wr0) begin
                unstable = 1;
            end
            if (stall_cnt < req_stall) begin
                bus_req_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus_req_ready = 1'b1;
                hs_addr   = bus_req_addr;
                hs_data   = bus_req_data;
                hs_wr     = bus_req_wr;
                seen_req  = 0;
                stall_cnt = 0;
                beat_i    = 0;
                gap_done  = 0;
                base_cur  = beat_base;
            end
        end else begin
            bus_req_ready = 1'b0;
        end
        if (bus_resp_ready) begin
            if (beat_i == gap_at && gap_done < gap_len) begin
                bus_resp_valid = 1'b0;
                gap_done++;
            end else begin
                bus_resp_valid = 1'b1;
                bus_resp_data  = base_cur + 64'(beat_i);
                beat_i++;
            end
        end else begin
            bus_resp_valid = 1'b0;
            bus_resp_data  = '0;
        end
    end

    function automatic logic [511:0] exp_line(input logic [63:0] addr, input logic [63:0] base);
        logic [511:0] l;
        logic [2:0]   w0;
        logic [2:0]   k;
`ifdef DCACHE_MEMIF_CWF_EN
        w0 = addr[5:3];
`else
        w0 = 3'd0;
`endif
        for (int i = 0; i < 8; i++) begin
            k = 3'(i) - w0;
            l[64*i +: 64] = base + 64'(k);
        end
        return l;
    endfunction

    function automatic logic [63:0] exp_rd_addr(input logic [63:0] addr);
`ifdef DCACHE_MEMIF_CWF_EN
        return addr & ~64'h7;
`else
        return addr & ~64'h3f;
`endif
    endfunction

    time t_pulse = 0;

    task automatic run_txn(input string tag, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input int exp_lat,
                           input logic [63:0] exp_addr, input logic [511:0] exp_block,
                           input bit hold);
        int n;
        unstable    = 0;
        cache_wr_en = wr;
        cache_addr  = addr;
        cache_wdata = wdata;
        cache_req   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_reqv"}, bus_req_valid, 1'b1);
                cache_addr  = ~addr;
                cache_wdata = ~wdata;
                cache_wr_en = ~wr;
            end
        end while (!cache_valid && n < 300);
        t_pulse = $time;
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_addr"}, hs_addr, exp_addr);
        chk({tag, "_wr"}, hs_wr, wr);
        chk({tag, "_data"}, hs_data, wdata);
        chk({tag, "_stable"}, unstable, 1'b0);
        chk({tag, "_block"}, cache_block, exp_block);
        if (!hold) cache_req = 1'b0;
        cache_wr_en = wr;
        @(negedge clk);
        chk({tag, "_pulse1"}, cache_valid, 1'b0);
    endtask

    initial begin
        logic [511:0] prev;
        time          t_first;
        int           pulses;

        repeat (3) @(negedge clk);
        chk("rst_valid", cache_valid, 1'b0);
        chk("rst_block", cache_block, '0);
        chk("rst_reqv", bus_req_valid, 1'b0);
        chk("rst_addr", bus_req_addr, '0);
        chk("rst_wr", bus_req_wr, 1'b0);
        chk("rst_data", bus_req_data, '0);
        chk("rst_rready", bus_resp_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rready", bus_resp_ready, 1'b0);

        // Plain fill, no stalls.
        beat_base = 64'h0;
        run_txn("fill0", 1'b0, 64'h1000, 64'h0, 10, 64'h1000, exp_line(64'h1000, 64'h0), 0);
        chk("fill0_w3", cache_block[64*3 +: 64], 64'h3);

        // Mid-line address: order depends on critical-word-first build.
        beat_base = 64'hA0;
        run_txn("fill28", 1'b0, 64'h1028, 64'h0, 10, exp_rd_addr(64'h1028),
                exp_line(64'h1028, 64'hA0), 0);
`ifdef DCACHE_MEMIF_CWF_EN
        chk("fill28_w5", cache_block[64*5 +: 64], 64'hA0);
        chk("fill28_w0", cache_block[64*0 +: 64], 64'hA3);
`else
        chk("fill28_w5", cache_block[64*5 +: 64], 64'hA5);
        chk("fill28_w0", cache_block[64*0 +: 64], 64'hA0);
`endif
        prev = cache_block;

        // Write with three request-stall cycles; line must be untouched.
        req_stall = 3;
        run_txn("wr", 1'b1, 64'h2008, 64'hDEADBEEF, 6, 64'h2008, prev, 0);
        req_stall = 0;

        // Five idle cycles between beats 3 and 4.
        beat_base = 64'h10;
        gap_at    = 4;
        gap_len   = 5;
        run_txn("gap", 1'b0, 64'h3000, 64'h0, 15, 64'h3000, exp_line(64'h3000, 64'h10), 0);
        gap_at  = -1;
        gap_len = 0;

        // Reset while beat 4 is being accepted.
        beat_base   = 64'h300;
        cache_wr_en = 1'b0;
        cache_addr  = 64'h4000;
        cache_req   = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_rready", bus_resp_ready, 1'b1);
        rst       = 1'b1;
        cache_req = 1'b0;
        @(negedge clk);
        chk("mid_valid", cache_valid, 1'b0);
        chk("mid_block", cache_block, '0);
        chk("mid_reqv", bus_req_valid, 1'b0);
        chk("mid_addr", bus_req_addr, '0);
        chk("mid_wr", bus_req_wr, 1'b0);
        chk("mid_data", bus_req_data, '0);
        chk("mid_rready0", bus_resp_ready, 1'b0);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cache_valid) pulses++;
        end
        chk("mid_nopulse", pulses, 0);
        beat_base = 64'h50;
        run_txn("after_rst", 1'b0, 64'h1000, 64'h0, 10, 64'h1000, exp_line(64'h1000, 64'h50), 0);

        // Request held high across two fills.
        beat_base = 64'h100;
        run_txn("b2b_a", 1'b0, 64'h1000, 64'h0, 10, 64'h1000, exp_line(64'h1000, 64'h100), 1);
        t_first   = t_pulse;
        beat_base = 64'h200;
        run_txn("b2b_b", 1'b0, 64'h1040, 64'h0, 10, 64'h1040, exp_line(64'h1040, 64'h200), 0);
        chk("b2b_spacing", 64'((t_pulse - t_first) / 10), 64'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
